alu_scheduler: RTL and testbench
================================

ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter EXEC_CYCLES, default 2, meaning ALU settle cycles per operation; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req0_valid / req1_valid  in  1  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  out  1  scheduler accepts requester N this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  in  32 signed  operands.
REQ-007 req0_op / req1_op  in  4  ALU opcode (0000 add ... 1111 pass A).
REQ-008 rsp0_valid / rsp1_valid  out  1  result for requester N available.
REQ-009 rsp0_ready / rsp1_ready  in  1  requester N consumes result.
REQ-010 rsp0_data / rsp1_data  out  32 signed  result.
REQ-011 rsp0_err / rsp1_err  out  1  divide/modulo by zero flagged.
REQ-012 alu_a, alu_b  out  32 signed; alu_sel  out  32; alu_y  in  32 signed: connection to the shared combinational ALU.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC, RESP; transitions IDLE->EXEC on request handshake, EXEC->RESP when the settle counter reaches 0, RESP->IDLE on response handshake.
REQ-015 In IDLE, reqN_ready SHALL equal (state==IDLE && grant==N), with exactly one grant when any reqN_valid is high, and no grant otherwise.
REQ-016 Arbitration SHALL be round-robin: with both valid, grant the requester indicated by pointer; with one valid, grant it regardless of pointer.
REQ-017 On request handshake, a, b, op and owner SHALL be latched; requesters may change inputs from the next cycle.
REQ-018 alu_a, alu_b SHALL be driven from latched operands and alu_sel = {28'b0, op} during EXEC and RESP; all three SHALL be 0 in IDLE.
REQ-019 On entering EXEC, the counter SHALL load EXEC_CYCLES-1; it decrements each EXEC cycle; on the cycle it is 0, alu_y SHALL be captured into the result register.
REQ-020 Latency: a request accepted in cycle T SHALL produce rspN_valid in cycle T+EXEC_CYCLES+1.
REQ-021 If op is 0011 or 0100 and latched b == 0, the captured result SHALL be 0 and err SHALL be 1; the op still takes EXEC_CYCLES.
REQ-022 In RESP, only the owner's rspN_valid SHALL be 1; data and err SHALL hold stable until rspN_ready.
REQ-023 On response handshake, pointer SHALL be set to the non-owner requester.
REQ-024 reqN_ready SHALL be 0 outside IDLE; no request is accepted in the cycle RESP->IDLE occurs.
REQ-025 Dropping reqN_valid before handshake SHALL be legal and SHALL cancel nothing.
REQ-026 Non-owner rspN_valid, rspN_data, rspN_err SHALL be 0.

Reset
REQ-027 With rst_n low at a clock edge: state IDLE, counter 0, pointer = requester 0, result 0, err 0; all outputs 0.
REQ-028 Reset during EXEC or RESP SHALL discard the operation without emitting a response.

Structure
REQ-029 Package alu_pkg SHALL hold the 4-bit opcode constants, FSM state typedef, and EXEC_CYCLES default.
REQ-030 Arbitration SHALL be a sub-module rr_arb2 (two valids + pointer in, one-hot grant out); the ALU stays external.

Verification
REQ-031 Single op: req0 a=7 b=5 op=0000 accepted T=0, EXEC_CYCLES=2 -> rsp0_valid at T=3, data 12, err 0.
REQ-032 Contention: both valid from reset, held -> grants 0,1,0,1 in order; rsp owners alternate.
REQ-033 Divide by zero: req1 a=9 b=0 op=0011 -> rsp1 data 0, err 1; next req1 a=-9 b=2 op=0011 -> data -4, err 0.
REQ-034 Backpressure: rsp0_ready low 5 cycles in RESP -> rsp0_valid, data stable, req1_ready 0 throughout.
REQ-035 Reset mid-EXEC: rst_n low one cycle -> no rsp, outputs 0, next request granted to req0 with full latency.
REQ-036 Operand change after accept: req0 a changes 100 -> 1 at T+1 -> result uses a=100.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: opcode encodings, FSM states and
// the default settle time of the external ALU.
package alu_pkg;

    localparam int DATA_W          = 32;
    localparam int EXEC_CYCLES_DEF = 2;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_MOD   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_SLT   = 4'b1011;
    localparam logic [3:0] OP_SLTU  = 4'b1100;
    localparam logic [3:0] OP_MIN   = 4'b1101;
    localparam logic [3:0] OP_MAX   = 4'b1110;
    localparam logic [3:0] OP_PASSA = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the pointer only breaks ties, a lone requester
// always wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant[ptr] = 1'b1;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one external combinational ALU between two requesters: arbitrate,
// hold operands for EXEC_CYCLES settle cycles, then present the result.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int EXEC_CYCLES = EXEC_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic signed [31:0] req0_a,
    input  logic signed [31:0] req0_b,
    input  logic [3:0]         req0_op,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic signed [31:0] req1_a,
    input  logic signed [31:0] req1_b,
    input  logic [3:0]         req1_op,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic signed [31:0] rsp0_data,
    output logic               rsp0_err,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic signed [31:0] rsp1_data,
    output logic               rsp1_err,
    output logic signed [31:0] alu_a,
    output logic signed [31:0] alu_b,
    output logic [31:0]        alu_sel,
    input  logic signed [31:0] alu_y,
    output logic               busy
);

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q;
    logic                      ptr_q;
    logic                      owner_q;
    logic [1:0]                grant;
    logic                      req_hs, rsp_hs, in_run;
    logic signed [DATA_W-1:0]  a_p0, b_p0;
    logic [3:0]                op_p0;
    logic signed [DATA_W-1:0]  result_p1;
    logic                      err_p1;

    function automatic logic is_divzero(input logic [3:0] op, input logic signed [DATA_W-1:0] b);
        return ((op == OP_DIV) || (op == OP_MOD)) && (b == '0);
    endfunction

    rr_arb2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // Ready is masked while rst_n is low so nothing handshakes under reset.
    assign req_hs = rst_n && (state_q == ST_IDLE) && (grant != 2'b00);
    assign rsp_hs = (state_q == ST_RESP) && (owner_q ? rsp1_ready : rsp0_ready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_hs)        state_d = ST_EXEC;
            ST_EXEC: if (cnt_q == 4'd0) state_d = ST_RESP;
            ST_RESP: if (rsp_hs)        state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Stage p0: operand latch on request handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            a_p0    <= '0;
            b_p0    <= '0;
            op_p0   <= 4'd0;
        end else begin
            state_q <= state_d;
            if (req_hs) begin
                owner_q <= grant[1];
                a_p0    <= grant[1] ? req1_a  : req0_a;
                b_p0    <= grant[1] ? req1_b  : req0_b;
                op_p0   <= grant[1] ? req1_op : req0_op;
                cnt_q   <= 4'(EXEC_CYCLES - 1);
            end else if ((state_q == ST_EXEC) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (rsp_hs) begin
                ptr_q <= ~owner_q;
            end
        end
    end

    // Stage p1: result capture on the last settle cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_p1 <= '0;
            err_p1    <= 1'b0;
        end else if ((state_q == ST_EXEC) && (cnt_q == 4'd0)) begin
            result_p1 <= is_divzero(op_p0, b_p0) ? '0 : alu_y;
            err_p1    <= is_divzero(op_p0, b_p0);
        end
    end

    assign in_run     = (state_q == ST_EXEC) || (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign req0_ready = req_hs && grant[0];
    assign req1_ready = req_hs && grant[1];
    assign alu_a      = in_run ? a_p0 : '0;
    assign alu_b      = in_run ? b_p0 : '0;
    assign alu_sel    = in_run ? {28'b0, op_p0} : 32'b0;
    assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
    assign rsp1_valid = (state_q == ST_RESP) && owner_q;
    assign rsp0_data  = rsp0_valid ? result_p1 : '0;
    assign rsp1_data  = rsp1_valid ? result_p1 : '0;
    assign rsp0_err   = rsp0_valid && err_p1;
    assign rsp1_err   = rsp1_valid && err_p1;

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler with a behavioural model of the shared ALU.
module tb_alu_scheduler;
    import alu_pkg::*;

    localparam int EXEC_CYCLES = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic signed [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_op, req1_op;
    logic rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
    logic signed [31:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_y;
    logic [31:0] alu_sel;
    logic busy;

    always #5 clk = ~clk;

    alu_scheduler #(.EXEC_CYCLES(EXEC_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
        .busy(busy)
    );

    typedef struct {
        logic               owner;
        logic signed [31:0] data;
        logic               err;
        int                 t_acc;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_rsp = 0;

    function automatic logic signed [31:0] alu_fn(input logic [3:0] op,
                                                  input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_DIV:  return (b == 0) ? 32'sh5EADBEEF : a / b;
            OP_MOD:  return (b == 0) ? 32'sh5EADBEEF : a % b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return a >>> b[4:0];
            OP_SLT:  return (a < b) ? 32'sd1 : 32'sd0;
            OP_SLTU: return ($unsigned(a) < $unsigned(b)) ? 32'sd1 : 32'sd0;
            OP_MIN:  return (a < b) ? a : b;
            OP_MAX:  return (a > b) ? a : b;
            default: return a;
        endcase
    endfunction

    assign alu_y = alu_fn(alu_sel[3:0], alu_a, alu_b);

    function automatic exp_t mk_exp(input logic owner, input logic [3:0] op,
                                    input logic signed [31:0] a,
                                    input logic signed [31:0] b, input int t);
        exp_t e;
        e.owner = owner;
        e.err   = ((op == OP_DIV) || (op == OP_MOD)) && (b == 0);
        e.data  = e.err ? 32'sd0 : alu_fn(op, a, b);
        e.t_acc = t;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: scoreboard push on accept, compare while a response is shown.
    initial begin : monitor
        logic rst_edge;
        logic own;
        forever begin
            @(posedge clk);
            rst_edge = !rst_n;
            cyc++;
            @(negedge clk);
            if (rst_edge) begin
                sb.delete();
                check("rst_busy", {31'b0, busy}, 32'd0);
                check("rst_rspv", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
                check("rst_rspd", rsp0_data | rsp1_data, 32'd0);
                check("rst_rspe", {30'b0, rsp1_err, rsp0_err}, 32'd0);
                check("rst_alu", alu_a | alu_b | alu_sel, 32'd0);
            end else begin
                check("rdy_busy", {31'b0, (req0_ready | req1_ready) & busy}, 32'd0);
                if (rsp0_valid || rsp1_valid) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 32'd1, 32'd0);
                    end else begin
                        own = sb[0].owner;
                        check("rsp_onehot", {31'b0, rsp0_valid & rsp1_valid}, 32'd0);
                        check("rsp_owner", {31'b0, rsp1_valid}, {31'b0, own});
                        check("rsp_data", own ? rsp1_data : rsp0_data, sb[0].data);
                        check("rsp_err", {31'b0, own ? rsp1_err : rsp0_err}, {31'b0, sb[0].err});
                        check("rsp_other", own ? (rsp0_data | {31'b0, rsp0_err})
                                               : (rsp1_data | {31'b0, rsp1_err}), 32'd0);
                        if (cyc - sb[0].t_acc == 1 + EXEC_CYCLES ||
                            (own ? !rsp1_ready : !rsp0_ready) || 1'b1) begin
                            if (sb[0].t_acc >= 0) begin
                                check("latency", cyc - sb[0].t_acc, EXEC_CYCLES + 1);
                                sb[0].t_acc = -1;
                            end
                        end
                        if (own ? rsp1_ready : rsp0_ready) begin
                            void'(sb.pop_front());
                            n_rsp++;
                        end
                    end
                end
            end
            check("grant_onehot", {31'b0, req0_ready & req1_ready}, 32'd0);
            if (req0_valid && req0_ready) begin
                sb.push_back(mk_exp(1'b0, req0_op, req0_a, req0_b, cyc));
                grant_log.push_back(0);
                n_acc++;
            end
            if (req1_valid && req1_ready) begin
                sb.push_back(mk_exp(1'b1, req1_op, req1_a, req1_b, cyc));
                grant_log.push_back(1);
                n_acc++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the handshake edge.
    task automatic issue(input int n, input logic signed [31:0] a,
                         input logic signed [31:0] b, input logic [3:0] op,
                         output int t_acc);
        bit ok = 0;
        t_acc = -1;
        if (n == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((n == 0) ? req0_ready : req1_ready) begin
                ok = 1;
                t_acc = cyc;
                break;
            end
        end
        if (!ok) check("issue_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (n == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    // Returns at the negedge where rspN_valid is first seen.
    task automatic wait_rsp(input int n, output int t_rsp);
        bit ok = 0;
        t_rsp = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((n == 0) ? rsp0_valid : rsp1_valid) begin
                ok = 1;
                t_rsp = cyc;
                break;
            end
        end
        if (!ok) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int ta, tr, acc0;
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 10; req0_b = 3; req0_op = OP_ADD;
        req1_a = 20; req1_b = 4; req1_op = OP_SUB;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Contention straight out of reset
        repeat (3) @(negedge clk);
        check("rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (n_acc >= 4) break;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        check("cont_count", grant_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("cont_grant", (i < grant_log.size()) ? grant_log[i] : 32'hFF, i % 2);
        end
        check("cont_rsps", n_rsp, 32'd4);

        // Single op with explicit latency
        issue(0, 7, 5, OP_ADD, ta);
        wait_rsp(0, tr);
        check("single_data", rsp0_data, 32'd12);
        check("single_err", {31'b0, rsp0_err}, 32'd0);
        check("single_lat", tr - ta, 32'd3);
        wait_idle();

        // Divide / modulo by zero, then a normal signed divide
        issue(1, 9, 0, OP_DIV, ta);
        wait_rsp(1, tr);
        check("div0_data", rsp1_data, 32'd0);
        check("div0_err", {31'b0, rsp1_err}, 32'd1);
        check("div0_lat", tr - ta, 32'd3);
        wait_idle();
        issue(1, -9, 2, OP_DIV, ta);
        wait_rsp(1, tr);
        check("div_data", rsp1_data, 32'hFFFF_FFFC);
        check("div_err", {31'b0, rsp1_err}, 32'd0);
        wait_idle();
        issue(0, 5, 0, OP_MOD, ta);
        wait_rsp(0, tr);
        check("mod0_err", {31'b0, rsp0_err}, 32'd1);
        wait_idle();

        // Operand change right after accept must not leak in
        issue(0, 100, 1, OP_ADD, ta);
        req0_a = 1;
        wait_rsp(0, tr);
        check("latch_data", rsp0_data, 32'd101);
        wait_idle();

        // Backpressure on rsp0 while req1 waits
        rsp0_ready = 1'b0;
        issue(0, 6, 7, OP_MUL, ta);
        req1_a = 3; req1_b = 4; req1_op = OP_SUB; req1_valid = 1'b1;
        wait_rsp(0, tr);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'b0, rsp0_valid}, 32'd1);
            check("bp_data", rsp0_data, 32'd42);
            check("bp_req1rdy", {31'b0, req1_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        acc0 = n_acc;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (n_acc > acc0) break;
        end
        check("bp_req1_acc", n_acc - acc0, 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_idle();

        // Reset during EXEC: pointer is 1 beforehand, must return to 0
        issue(0, 1, 2, OP_ADD, ta);
        wait_idle();
        issue(1, 50, 60, OP_ADD, ta);
        check("rst_mid_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        grant_log.delete();
        req0_a = 11; req0_b = 22; req0_op = OP_XOR; req0_valid = 1'b1;
        req1_a = 33; req1_b = 44; req1_op = OP_OR;  req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_norsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (grant_log.size() >= 1) break;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        check("rst_first_grant", (grant_log.size() > 0) ? grant_log[0] : 32'hFF, 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (grant_log.size() >= 2) break;
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_idle();

        // Mixed random traffic
        for (int k = 0; k < 12; k++) begin
            issue(k % 2, $signed($urandom_range(0, 2000)) - 1000,
                  $signed($urandom_range(0, 20)) - 5, 4'($urandom_range(0, 15)), ta);
            wait_idle();
        end
        check("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
